// File: rtl/mem_output_capture.sv
// mem_output_capture: sink that captures a valid-qualified result stream into
// an internal memory, counts words, keeps a modular checksum and a sticky
// overflow flag, and pulses done once the programmed word count has arrived.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   start         one-cycle pulse; arms a new capture (clears count/sum/flags)
//   num_of_dat    number of words to capture, sampled with start
//   dat_in        stream data, qualified by dat_in_vld
//   rd_addr       readback address; rd_data returns mem[rd_addr] one cycle later
//   busy          high while capturing
//   done          one-cycle pulse when the capture completes
//   word_cnt      words accepted in the current or last capture
//   checksum      modulo 2^WIDTH sum of accepted words
//   overflow      sticky; a word was dropped
module mem_output_capture #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 32,
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_of_dat,
    input  logic [WIDTH-1:0] dat_in,
    input  logic             dat_in_vld,
    input  logic [CNT_W-1:0] rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] word_cnt,
    output logic [WIDTH-1:0] checksum,
    output logic             overflow
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        FINISH  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] target_q, target_d;
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic [WIDTH-1:0] checksum_q, checksum_d;
    logic             overflow_q, overflow_d;
    logic             completed_q, completed_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             mem_we_c;

    logic [WIDTH-1:0] mem [DEPTH];

    // Next-state, counters and flags; start overrides every state.
    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        word_cnt_d  = word_cnt_q;
        checksum_d  = checksum_q;
        overflow_d  = overflow_q;
        completed_d = completed_q;
        mem_we_c    = 1'b0;

        if (start) begin
            state_d     = CAPTURE;
            target_d    = num_of_dat;
            word_cnt_d  = '0;
            checksum_d  = '0;
            overflow_d  = 1'b0;
            completed_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    // Extra words after a finished capture are dropped.
                    if (dat_in_vld && completed_q) begin
                        overflow_d = 1'b1;
                    end
                end
                CAPTURE: begin
                    if (target_q == '0) begin
                        state_d = FINISH;
                    end else if (dat_in_vld && (word_cnt_q < target_q)) begin
                        // Words past DEPTH are still counted and summed.
                        mem_we_c   = (word_cnt_q < CNT_W'(DEPTH));
                        overflow_d = overflow_q | ~mem_we_c;
                        word_cnt_d = word_cnt_q + CNT_W'(1);
                        checksum_d = checksum_q + dat_in;
                        if ((word_cnt_q + CNT_W'(1)) == target_q) begin
                            state_d = FINISH;
                        end
                    end
                end
                FINISH: begin
                    state_d     = IDLE;
                    completed_d = 1'b1;
                    if (dat_in_vld) begin
                        overflow_d = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d == CAPTURE);
        done_d = (state_d == FINISH);
    end

    // Readback mux; out-of-range addresses read as zero.
    always_comb begin
        rd_data_d = '0;
        if (rd_addr < CNT_W'(DEPTH)) begin
            rd_data_d = mem[rd_addr[AW-1:0]];
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            target_q    <= '0;
            word_cnt_q  <= '0;
            checksum_q  <= '0;
            overflow_q  <= 1'b0;
            completed_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            word_cnt_q  <= word_cnt_d;
            checksum_q  <= checksum_d;
            overflow_q  <= overflow_d;
            completed_q <= completed_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rd_data_q   <= rd_data_d;
        end
    end

    // Capture memory; intentionally not reset.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            mem[word_cnt_q[AW-1:0]] <= dat_in;
        end
    end

    assign rd_data  = rd_data_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign word_cnt = word_cnt_q;
    assign checksum = checksum_q;
    assign overflow = overflow_q;

endmodule
